// File: rtl/word_mux_pkg.sv
// word_mux_pkg: sizing helpers and beat sideband type shared by
// the word_mux_tree_pipe slice.
package word_mux_pkg;

    localparam int DEF_DWIDTH   = 32;
    localparam int DEF_WORDS_IN = 16;
    localparam int DEF_SEL_NUM  = 2;
    localparam int DEF_TAG_W    = 4;
    localparam int DEF_IDX_W    = $clog2(DEF_WORDS_IN);

    function automatic int calc_layers(input int words, input int sel);
        return $clog2(words) / sel;
    endfunction

    function automatic int words_at(input int words, input int sel, input int k);
        return words >> (sel * (k + 1));
    endfunction

    typedef struct packed {
        logic [DEF_IDX_W-1:0] idx;
        logic [DEF_TAG_W-1:0] tag;
    } sb_t;

endpackage

// File: rtl/word_mux_tree_pipe_if.sv
// word_mux_tree_pipe_if: producer/consumer handshake bundle.
// master = stimulus and consumer side, slave = the mux tree pipe.
interface word_mux_tree_pipe_if
    import word_mux_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int WORDS_IN = DEF_WORDS_IN,
    parameter int IDX_W    = $clog2(WORDS_IN),
    parameter int TAG_W    = DEF_TAG_W,
    parameter int OCC_W    = $clog2(calc_layers(WORDS_IN, DEF_SEL_NUM) + 1)
);

    logic                       in_valid;
    logic                       in_ready;
    logic [IDX_W-1:0]           in_idx;
    logic [TAG_W-1:0]           in_tag;
    logic [DWIDTH*WORDS_IN-1:0] in_data;
    logic                       out_valid;
    logic                       out_ready;
    logic [DWIDTH-1:0]          out_data;
    logic [IDX_W-1:0]           out_idx;
    logic [TAG_W-1:0]           out_tag;
    logic [OCC_W-1:0]           occ;

    modport master (
        output in_valid, in_idx, in_tag, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_tag, occ
    );

    modport slave (
        input  in_valid, in_idx, in_tag, in_data, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_tag, occ
    );

endinterface

// File: rtl/word_mux_tree_stage.sv
// word_mux_tree_stage: one registered N_TO_1 reduction layer with
// valid/idx/tag pass-through, loading only when i_en is high.
module word_mux_tree_stage #(
    parameter int DWIDTH  = 32,
    parameter int WORDS   = 16,
    parameter int SEL_NUM = 2,
    parameter int IDX_W   = 4,
    parameter int TAG_W   = 4,
    parameter int LVL     = 0,
    localparam int N_TO_1 = 1 << SEL_NUM,
    localparam int WO     = WORDS / N_TO_1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_en,
    input  logic                    i_v,
    input  logic [DWIDTH*WORDS-1:0] i_data,
    input  logic [IDX_W-1:0]        i_idx,
    input  logic [TAG_W-1:0]        i_tag,
    output logic                    o_v,
    output logic [DWIDTH*WO-1:0]    o_data,
    output logic [IDX_W-1:0]        o_idx,
    output logic [TAG_W-1:0]        o_tag
);

    logic [SEL_NUM-1:0]   w_sel;
    logic [DWIDTH*WO-1:0] w_red;
    logic                 r_v;
    logic [DWIDTH*WO-1:0] r_data;
    logic [IDX_W-1:0]     r_idx;
    logic [TAG_W-1:0]     r_tag;

    assign w_sel = i_idx[SEL_NUM*LVL +: SEL_NUM];

    always_comb begin
        w_red = '0;
        for (int g = 0; g < WO; g++) begin
            w_red[DWIDTH*g +: DWIDTH] =
                i_data[DWIDTH*(g*N_TO_1 + int'(w_sel)) +: DWIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_v    <= 1'b0;
            r_data <= '0;
            r_idx  <= '0;
            r_tag  <= '0;
        end else if (i_en) begin
            r_v    <= i_v;
            r_data <= w_red;
            r_idx  <= i_idx;
            r_tag  <= i_tag;
        end
    end

    assign o_v    = r_v;
    assign o_data = r_data;
    assign o_idx  = r_idx;
    assign o_tag  = r_tag;

endmodule

// File: rtl/word_mux_tree_pipe.sv
// word_mux_tree_pipe: handshaked LAYERS-deep registered word-select tree.
// Define WORD_MUX_TREE_BUBBLE_COLLAPSE_EN for per-stage bubble-collapsing enables.
module word_mux_tree_pipe
    import word_mux_pkg::*;
#(
    parameter int DWIDTH   = DEF_DWIDTH,
    parameter int WORDS_IN = DEF_WORDS_IN,
    parameter int SEL_NUM  = DEF_SEL_NUM,
    parameter int TAG_W    = DEF_TAG_W,
    localparam int IDX_W   = $clog2(WORDS_IN),
    localparam int LAYERS  = calc_layers(WORDS_IN, SEL_NUM),
    localparam int OCC_W   = $clog2(LAYERS + 1)
) (
    input  logic                clk,
    input  logic                rst,
    word_mux_tree_pipe_if.slave bus
);

    if ((IDX_W % SEL_NUM) != 0) begin : g_bad_cfg
        $error("word_mux_tree_pipe: IDX_W must be a multiple of SEL_NUM");
    end

    logic [LAYERS-1:0]             w_v;
    logic [LAYERS-1:0][IDX_W-1:0]  w_idx;
    logic [LAYERS-1:0][TAG_W-1:0]  w_tag;
    logic [LAYERS-1:0]             w_en;
    logic                          w_in_fire;
    logic                          w_out_fire;
    logic                          r_guard;
    logic [OCC_W-1:0]              r_occ;

`ifdef WORD_MUX_TREE_BUBBLE_COLLAPSE_EN
    // A stage may load whenever it is empty or its successor moves.
    always_comb begin
        w_en = '0;
        w_en[LAYERS-1] = !w_v[LAYERS-1] || bus.out_ready;
        for (int k = LAYERS - 2; k >= 0; k--) begin
            w_en[k] = !w_v[k] || w_en[k+1];
        end
    end
`else
    assign w_en = {LAYERS{!w_v[LAYERS-1] || bus.out_ready}};
`endif

    assign w_in_fire  = bus.in_valid && r_guard && w_en[0];
    assign w_out_fire = w_v[LAYERS-1] && bus.out_ready;

    for (genvar k = 0; k < LAYERS; k++) begin : g_st
        localparam int WI = WORDS_IN >> (SEL_NUM * k);
        localparam int WO = words_at(WORDS_IN, SEL_NUM, k);
        logic [DWIDTH*WI-1:0] w_din;
        logic [DWIDTH*WO-1:0] w_dout;
        logic                 w_vin;
        logic [IDX_W-1:0]     w_iin;
        logic [TAG_W-1:0]     w_tin;
        if (k == 0) begin : g_src
            assign w_din = bus.in_data;
            assign w_vin = w_in_fire;
            assign w_iin = bus.in_idx;
            assign w_tin = bus.in_tag;
        end else begin : g_src
            assign w_din = g_st[k-1].w_dout;
            assign w_vin = w_v[k-1];
            assign w_iin = w_idx[k-1];
            assign w_tin = w_tag[k-1];
        end
        word_mux_tree_stage #(
            .DWIDTH (DWIDTH),
            .WORDS  (WI),
            .SEL_NUM(SEL_NUM),
            .IDX_W  (IDX_W),
            .TAG_W  (TAG_W),
            .LVL    (k)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .i_en  (w_en[k]),
            .i_v   (w_vin),
            .i_data(w_din),
            .i_idx (w_iin),
            .i_tag (w_tin),
            .o_v   (w_v[k]),
            .o_data(w_dout),
            .o_idx (w_idx[k]),
            .o_tag (w_tag[k])
        );
    end

    // Guard keeps in_ready low for the first cycle after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_guard <= 1'b0;
            r_occ   <= '0;
        end else begin
            r_guard <= 1'b1;
            unique case (1'b1)
                w_in_fire && !w_out_fire: r_occ <= r_occ + 1'b1;
                w_out_fire && !w_in_fire: r_occ <= r_occ - 1'b1;
                default:                  r_occ <= r_occ;
            endcase
        end
    end

    assign bus.in_ready  = r_guard && w_en[0];
    assign bus.out_valid = w_v[LAYERS-1];
    assign bus.out_data  = g_st[LAYERS-1].w_dout;
    assign bus.out_idx   = w_idx[LAYERS-1];
    assign bus.out_tag   = w_tag[LAYERS-1];
    assign bus.occ       = r_occ;

    a_occ_max: assert property (@(posedge clk) disable iff (!rst)
        int'(r_occ) <= LAYERS);
    a_occ_uf: assert property (@(posedge clk) disable iff (!rst)
        !(r_occ == '0 && w_out_fire && !w_in_fire));
    a_occ_v: assert property (@(posedge clk) disable iff (!rst)
        int'(r_occ) == $countones(w_v));

endmodule

// File: tb/tb_word_mux_tree_pipe.sv
// tb_word_mux_tree_pipe: directed and random checks of the word mux
// tree pipe against hand values and a beat-level reference model.
module tb_word_mux_tree_pipe;
    import word_mux_pkg::*;

    localparam int DW = 32;
    localparam int WI = 16;
    localparam int SN = 2;
    localparam int TW = 4;
    localparam int IW = $clog2(WI);
    localparam int L  = calc_layers(WI, SN);
    localparam int OW = $clog2(L + 1);

    typedef struct {
        logic [DW-1:0] d;
        sb_t           sb;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    logic [L-1:0]     mv;
    logic             mg;
    exp_t             q[$];
    logic [DW*WI-1:0] pat;

    always #5 clk = ~clk;

    word_mux_tree_pipe_if #(
        .DWIDTH(DW), .WORDS_IN(WI), .IDX_W(IW), .TAG_W(TW), .OCC_W(OW)
    ) bus ();

    word_mux_tree_pipe #(
        .DWIDTH(DW), .WORDS_IN(WI), .SEL_NUM(SN), .TAG_W(TW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int idx, input int tag,
                         input logic ordy);
        bus.in_valid  = v;
        bus.in_idx    = IW'(idx);
        bus.in_tag    = TW'(tag);
        bus.in_data   = pat;
        bus.out_ready = ordy;
    endtask

    task automatic model_reset();
        mv = '0;
        mg = 1'b0;
        q.delete();
    endtask

    // Check one cycle against the model, advance the model, clock once.
    task automatic step(output logic fired);
        logic [L-1:0] en;
        logic         ifire;
        logic         ofire;
        exp_t         e;
        #1;
`ifdef WORD_MUX_TREE_BUBBLE_COLLAPSE_EN
        en[L-1] = !mv[L-1] || bus.out_ready;
        for (int k = L - 2; k >= 0; k--) en[k] = !mv[k] || en[k+1];
`else
        en = {L{!mv[L-1] || bus.out_ready}};
`endif
        chk("in_ready", bus.in_ready, mg && en[0]);
        chk("out_valid", bus.out_valid, mv[L-1]);
        chk("occ", bus.occ, $countones(mv));
        ifire = bus.in_valid && mg && en[0];
        ofire = mv[L-1] && bus.out_ready;
        if (mv[L-1]) begin
            chk("out_data", bus.out_data, q[0].d);
            chk("out_idx", bus.out_idx, q[0].sb.idx);
            chk("out_tag", bus.out_tag, q[0].sb.tag);
            if (ofire) void'(q.pop_front());
        end
        if (ifire) begin
            e.d      = pat[DW*int'(bus.in_idx) +: DW];
            e.sb.idx = bus.in_idx;
            e.sb.tag = bus.in_tag;
            q.push_back(e);
        end
        for (int k = L - 1; k > 0; k--) if (en[k]) mv[k] = mv[k-1];
        if (en[0]) mv[0] = ifire;
        mg    = 1'b1;
        fired = ifire;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic f;
        int   nb;
        int   sent;
        int   cyc;

        for (int i = 0; i < WI; i++) pat[DW*i +: DW] = 32'hA000_0000 + i;
        model_reset();
        drive(1'b0, 0, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 32'h0);
        chk("rst_out_idx", bus.out_idx, 4'h0);
        chk("rst_out_tag", bus.out_tag, 4'h0);
        chk("rst_occ", bus.occ, 2'd0);
        chk("rst_in_ready", bus.in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("guard_ready", bus.in_ready, 1'b0);

        // single beat
        drive(1'b0, 0, 0, 1'b1);
        step(f);
        drive(1'b1, 9, 3, 1'b1);
        step(f);
        drive(1'b0, 0, 0, 1'b1);
        chk("t1_occ_a", bus.occ, 2'd1);
        chk("t1_ov_a", bus.out_valid, 1'b0);
        step(f);
        chk("t1_ov_b", bus.out_valid, 1'b1);
        chk("t1_data", bus.out_data, 32'hA000_0009);
        chk("t1_idx", bus.out_idx, 4'd9);
        chk("t1_tag", bus.out_tag, 4'd3);
        chk("t1_occ_b", bus.occ, 2'd1);
        step(f);
        chk("t1_occ_c", bus.occ, 2'd0);
        chk("t1_ov_c", bus.out_valid, 1'b0);

        // back-to-back, every index
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, i, 15 - i, 1'b1);
            step(f);
            if (i == 8) begin
                chk("b2b_occ", bus.occ, 2'd2);
                chk("b2b_data", bus.out_data, 32'hA000_0007);
            end
        end
        drive(1'b0, 0, 0, 1'b1);
        repeat (3) step(f);

        // stalled output with three beats offered
        nb = 0;
        for (int c = 0; c < 5; c++) begin
            drive(nb < 3, 12 - nb, nb, 1'b0);
            step(f);
            if (f) nb++;
        end
        drive(nb < 3, 12 - nb, nb, 1'b0);
        chk("stall_occ", bus.occ, 2'd2);
        chk("stall_rdy", bus.in_ready, 1'b0);
        chk("stall_data", bus.out_data, 32'hA000_000C);
        chk("stall_tag", bus.out_tag, 4'd0);
        for (int c = 0; c < 20 && (nb < 3 || q.size() != 0); c++) begin
            drive(nb < 3, 12 - nb, nb, 1'b1);
            step(f);
            if (f) nb++;
        end
        chk("stall_sent", nb, 3);
        chk("stall_drain", q.size(), 0);

        // asynchronous reset mid-stream
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, i, i, 1'b1);
            step(f);
        end
        chk("pre_rst_occ", bus.occ, 2'd2);
        rst = 1'b0;
        #1;
        chk("arst_ov", bus.out_valid, 1'b0);
        chk("arst_occ", bus.occ, 2'd0);
        chk("arst_rdy", bus.in_ready, 1'b0);
        model_reset();
        drive(1'b0, 0, 0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rel_guard", bus.in_ready, 1'b0);
        drive(1'b1, 15, 5, 1'b1);
        step(f);
        step(f);
        drive(1'b0, 0, 0, 1'b1);
        step(f);
        chk("post_rst_ov", bus.out_valid, 1'b1);
        chk("post_rst_data", bus.out_data, 32'hA000_000F);
        chk("post_rst_tag", bus.out_tag, 4'd5);
        step(f);
        chk("post_rst_occ", bus.occ, 2'd0);

        // random traffic with random word contents
        sent = 0;
        cyc  = 0;
        while ((sent < 10000 || q.size() != 0) && cyc < 80000) begin
            for (int i = 0; i < WI; i++) pat[DW*i +: DW] = $urandom;
            drive(sent < 10000 && $urandom_range(0, 3) != 0,
                  $urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 3) != 0);
            step(f);
            if (f) sent++;
            cyc++;
        end
        chk("rand_sent", sent, 10000);
        chk("rand_drain", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
